// File: rtl/usr_sequencer.sv
// Command sequencer that drives the ctrl/d inputs of one universal shift register.
// Optional one-entry command buffer: define USR_SEQUENCER_CMDBUF_EN.
module usr_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [1:0]       usr_ctrl,
  output logic [WIDTH-1:0] usr_d,
  input  logic [WIDTH-1:0] usr_q,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_SHR   = 2'b01;
  localparam logic [1:0] OP_SHL   = 2'b10;
  localparam logic [1:0] OP_LDSHR = 2'b11;

  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_SHR  = 2'b01;
  localparam logic [1:0] CTRL_SHL  = 2'b10;
  localparam logic [1:0] CTRL_LOAD = 2'b11;

  state_t           state, state_nxt, launch_state;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rst_done;
  logic             accept;
  logic             launch;
  logic [1:0]       launch_op;
  logic [CNT_W-1:0] launch_cnt;

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready never depends on cmd_valid, and cmd_*
  // are don't-care whenever cmd_ready is low.
  assign accept = cmd_valid & cmd_ready;

`ifdef USR_SEQUENCER_CMDBUF_EN
  logic             buf_full;
  logic [1:0]       buf_op;
  logic [CNT_W-1:0] buf_cnt;

  // usr_d already holds the buffered command's data, since nothing else can
  // be accepted while the buffer is full.
  assign cmd_ready  = rst_done & ~buf_full;
  assign launch     = ((state == S_IDLE) & accept) |
                      ((state == S_DONE) & (buf_full | accept));
  assign launch_op  = buf_full ? buf_op  : cmd_op;
  assign launch_cnt = buf_full ? buf_cnt : cmd_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_full <= 1'b0;
      buf_op   <= '0;
      buf_cnt  <= '0;
    end else if (accept && !launch) begin
      buf_full <= 1'b1;
      buf_op   <= cmd_op;
      buf_cnt  <= cmd_count;
    end else if (launch && buf_full) begin
      buf_full <= 1'b0;
    end
  end
`else
  assign cmd_ready  = rst_done & (state == S_IDLE);
  assign launch     = accept;
  assign launch_op  = cmd_op;
  assign launch_cnt = cmd_count;
`endif

  always_comb begin
    launch_state = S_DONE;
    if (launch_op == OP_LOAD || launch_op == OP_LDSHR) begin
      launch_state = S_LOAD;
    end else if (launch_cnt != '0) begin
      launch_state = S_SHIFT;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (launch) state_nxt = launch_state;
      S_LOAD:  state_nxt = (op_q == OP_LDSHR && cnt_q != '0) ? S_SHIFT : S_DONE;
      S_SHIFT: if (cnt_q == CNT_W'(1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = launch ? launch_state : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    usr_ctrl = CTRL_HOLD;
    case (state)
      S_LOAD:  usr_ctrl = CTRL_LOAD;
      S_SHIFT: usr_ctrl = (op_q == OP_SHL) ? CTRL_SHL : CTRL_SHR;
      default: usr_ctrl = CTRL_HOLD;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      op_q      <= OP_LOAD;
      cnt_q     <= '0;
      usr_d     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      rst_done  <= 1'b0;
    end else begin
      rst_done  <= 1'b1;
      state     <= state_nxt;
      res_valid <= (state == S_DONE);
      if (state == S_DONE) res_data <= usr_q;
      if (accept) usr_d <= cmd_data;
      if (launch) begin
        op_q  <= launch_op;
        cnt_q <= launch_cnt;
      end else if (state == S_SHIFT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // op encodings not referenced by name above are still part of the command set
  logic unused_ops;
  assign unused_ops = ^{OP_SHR};

endmodule
